// File: rtl/soma_acum_bcd_pkg.sv
// soma_pkg: shared state encoding, seven-segment patterns and sizing helper
package soma_pkg;
  typedef enum logic [1:0] {IDLE, CALC, CONV, SHOW} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  function automatic int min_digits(input int w);
    int v, d;
    v = (1 << (w + 1)) - 1;
    d = 0;
    while (v > 0) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/soma_acum_bcd_seg7.sv
// seg7_bcd: one BCD digit to active-low segments, blank when asked or invalid
module seg7_bcd
  import soma_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  assign seg = (blank || bcd > 4'd9) ? SEG_BLANK : SEG_TABLE[bcd];
endmodule

// File: rtl/soma_acum_bcd.sv
// soma_acum_bcd: registered add/sub/accumulate with double-dabble BCD display
module soma_acum_bcd
  import soma_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      A,
  input  logic [WIDTH-1:0]      B,
  input  logic                  cin,
  input  logic                  sub,
  input  logic                  acc,
  output logic [WIDTH:0]        result,
  output logic                  neg,
  output logic                  busy,
  output logic                  done,
  output logic [7*DIGITS-1:0]   HEX
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  if (WIDTH < 2 || WIDTH > 16 || DIGITS < min_digits(WIDTH)) begin : g_bad
    $error("soma_acum_bcd: DIGITS too small for WIDTH or WIDTH out of range");
  end
  state_t           state;
  logic [WIDTH-1:0] acc_reg, op_a, diff;
  logic [WIDTH:0]   sum, res_nxt;
  logic             ge;
  logic [SW-1:0]    sh, adj, sh_nxt;
  logic [BW-1:0]    disp;
  logic [CW-1:0]    cnt;
  assign op_a    = acc ? acc_reg : A;
  assign ge      = op_a >= B;
  assign diff    = ge ? op_a - B : B - op_a;
  assign sum     = {1'b0, op_a} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign res_nxt = sub ? {1'b0, diff} : sum;
  assign sh_nxt  = {adj[SW-2:0], 1'b0};
  // add-3 correction on every BCD nibble ahead of the shift
  always_comb begin
    adj = sh;
    for (int k = 0; k < DIGITS; k++)
      adj[WIDTH+1+4*k +: 4] = sh[WIDTH+1+4*k +: 4] >= 4'd5 ? sh[WIDTH+1+4*k +: 4] + 4'd3 : sh[WIDTH+1+4*k +: 4];
  end
  // operation sequencing; result is computed on the start edge so it is valid in CALC
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      result  <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_reg <= '0;
      sh      <= '0;
      disp    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          result <= res_nxt;
          neg    <= sub && !ge;
          busy   <= 1'b1;
          state  <= CALC;
          if (acc) acc_reg <= res_nxt[WIDTH-1:0];
        end
        CALC: begin
          sh    <= {{BW{1'b0}}, result};
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          sh  <= sh_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH)) begin
            disp  <= sh_nxt[SW-1 -: BW];
            done  <= 1'b1;
            state <= SHOW;
          end
        end
        SHOW: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    seg7_bcd u_seg (
      .bcd  (disp[4*i +: 4]),
      .blank(i != 0 && disp[BW-1:4*i] == '0),
      .seg  (HEX[7*i +: 7])
    );
  end
endmodule

// File: doc/soma_acum_bcd.md
Name: soma_acum_bcd

Overview:
- Parametrised, registered successor to the team's 4-bit switch adder.
- Adds or subtracts two WIDTH-bit operands, or accumulates B into an internal register. Holds the result, converts it to BCD with an iterative shift-add-3 (double-dabble) engine, and drives DIGITS active-low seven-segment displays.
- Sits between board switches/keys and the HEX displays; one start pulse per operation.

Parameters:
- WIDTH, 4, operand width in bits (2..16).
- DIGITS, 2, number of decimal display digits. Must satisfy 10^DIGITS > 2^(WIDTH+1)-1; elaboration error otherwise.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle operation request. Sampled only in IDLE.
- A  in  WIDTH  operand A. Ignored when acc=1.
- B  in  WIDTH  operand B.
- cin  in  1  carry-in for add/accumulate. Ignored for subtract.
- sub  in  1  0 = add, 1 = subtract (A-B).
- acc  in  1  1 = accumulate mode (uses acc_reg in place of A).
- result  out  WIDTH+1  registered result: sum with carry, or magnitude of difference.
- neg  out  1  1 when subtract result is negative.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when HEX is updated.
- HEX  out  7*DIGITS  segments. Digit i occupies bits [7*i +: 7]; bit 7*i+0 = seg a … 7*i+6 = seg g; active-low. Digit 0 is units.

Behaviour:
- Reset values: result=0, neg=0, busy=0, done=0, acc_reg=0, state=IDLE. HEX shows "0" on digit 0 and blank (all 1s) on higher digits.
- States: IDLE -> CALC -> CONV -> SHOW -> IDLE.
- IDLE:
  - start=1: latch A, B, cin, sub, acc; go to CALC.
  - start=0: stay in IDLE.
- CALC (1 cycle):
  - Add: result = op_a + B + cin, width WIDTH+1, no overflow possible.
  - Sub: if A>=B, result = A-B and neg=0; else result = B-A and neg=1. cin is ignored.
  - acc=1: op_a = acc_reg, otherwise op_a = A. acc_reg <= result[WIDTH-1:0]; the carry in result[WIDTH] is visible in result, but acc_reg wraps modulo 2^WIDTH.
  - acc=0: acc_reg is unchanged.
  - acc=1 and sub=1: acc_reg - B, with the same magnitude/neg rule; acc_reg <= magnitude.
  - Load the BCD shift register with zeros plus result. Set busy=1.
- CONV: exactly WIDTH+1 cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left 1.
- SHOW (1 cycle):
  - Decode the BCD nibbles into HEX.
  - Leading zeros are blanked; digit 0 always shows.
  - neg is not drawn on HEX; it is reported only on the neg port.
  - done=1 for this cycle only; busy=0 from the next cycle.
- Latency: start sampled at edge n.
  - result/neg valid from cycle n+1.
  - busy high cycles n+1 … n+WIDTH+3.
  - done and new HEX in cycle n+WIDTH+3; HEX holds until the next SHOW.
- start while busy is ignored, not queued. start in the SHOW cycle is also ignored.
- Inputs changing after latch do not affect the current operation.
- Reset mid-operation (any state) aborts it: all outputs and acc_reg return to reset values on the next edge.
- Max result 2^(WIDTH+1)-1 (e.g. 31 for WIDTH=4) must display correctly.

Decomposition:
- Package soma_pkg:
  - state enum (IDLE, CALC, CONV, SHOW).
  - SEG_BLANK = 7'b1111111.
  - seven-segment pattern constants for digits 0-9.
  - function computing the minimum DIGITS, for the elaboration check.
- Sub-module seg7_bcd: 4-bit BCD plus blank flag in, 7 active-low segments out. Instantiated DIGITS times by generate.

Test Plan (WIDTH=4, DIGITS=2 unless stated):
- Reset, then idle 5 cycles -> HEX digit0 = "0", digit1 blank, result=0, done never pulses.
- A=15, B=15, cin=1, sub=0, start -> result=31 at n+1; done in cycle n+7; HEX = "3","1"; busy high exactly 7 cycles.
- A=3, B=9, sub=1, start -> result=6, neg=1, HEX digit0 "6", digit1 blank.
- acc=1, B=9, start three times, cin=0 -> results 9, 18 (acc_reg=2), 11; displays "9", "18", "11".
- start re-asserted every cycle during CONV -> exactly one done per accepted op; reset asserted in CONV -> busy=0, HEX reset pattern next cycle.
- WIDTH=8, DIGITS=3: A=255, B=255, cin=1 -> result=511, HEX = "5","1","1", done at n+11.
